// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Covers controller states, forwarding selects and the per-cycle stall/flush control word.
package riscv_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERROR    = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
  } hz_ctrl_t;

  // A write to x0 never produces a value worth forwarding or waiting on.
  function automatic logic rd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: register indices and stage status in,
// forwarding selects, stalls, flushes and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D_i;
  logic [4:0]       rs2D_i;
  logic [4:0]       rs1E_i;
  logic [4:0]       rs2E_i;
  logic [4:0]       rdE_i;
  logic [1:0]       resultSrcE_i;
  logic             pcSrcE_i;
  logic [4:0]       rdM_i;
  logic [4:0]       rdW_i;
  logic             regWriteM_i;
  logic             regWriteW_i;
  logic             memReqM_i;
  logic             memAckM_i;
  logic [1:0]       forwardAE_o;
  logic [1:0]       forwardBE_o;
  logic             stallF_o;
  logic             stallD_o;
  logic             stallE_o;
  logic             stallM_o;
  logic             stallW_o;
  logic             flushD_o;
  logic             flushE_o;
  logic             memErr_o;
  logic [CNT_W-1:0] stallCnt_o;

  modport master (
    output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, resultSrcE_i, pcSrcE_i,
           rdM_i, rdW_i, regWriteM_i, regWriteW_i, memReqM_i, memAckM_i,
    input  forwardAE_o, forwardBE_o, stallF_o, stallD_o, stallE_o, stallM_o,
           stallW_o, flushD_o, flushE_o, memErr_o, stallCnt_o
  );

  modport slave (
    input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, resultSrcE_i, pcSrcE_i,
           rdM_i, rdW_i, regWriteM_i, regWriteW_i, memReqM_i, memAckM_i,
    output forwardAE_o, forwardBE_o, stallF_o, stallD_o, stallE_o, stallM_o,
           stallW_o, flushD_o, flushE_o, memErr_o, stallCnt_o
  );

endinterface

// File: rtl/hazard_ctrl_chk.sv
// Invariants of the hazard controller outputs, kept apart from the design logic.
module hazard_ctrl_chk #(
  parameter int CNT_W = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             in_error,
  input logic             stall_e,
  input logic             flush_d,
  input logic             flush_e,
  input logic             mem_err,
  input logic [CNT_W-1:0] stall_cnt
);

  a_freeze_no_flush: assert property (@(posedge clk_i) disable iff (rst_i)
    stall_e |-> (!flush_d && !flush_e));

  a_err_only_in_error: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_err |-> in_error);

  a_cnt_saturates: assert property (@(posedge clk_i) disable iff (rst_i)
    (stall_cnt == {CNT_W{1'b1}}) |=> (stall_cnt == {CNT_W{1'b1}}));

endmodule

// File: rtl/hazard_ctrl_forward.sv
// Operand forwarding select for one E-stage source register.
// The M-stage ALU result is younger than the W-stage result, so it wins.
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  // Priority select between M result, W result and the register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (rd_hit(reg_write_m, rd_m, rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (rd_hit(reg_write_w, rd_w, rs_e)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: forwarding, load-use stalls,
// branch flushes, post-reset scrub, memory-wait freeze with timeout, stall-cycle counter.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int INIT_CYCLES = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam int CNT_MAX = (INIT_CYCLES > MEM_TIMEOUT) ? INIT_CYCLES : MEM_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(MEM_TIMEOUT - 1);

  ctrl_state_t      state_r;
  ctrl_state_t      state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             mem_err_r;
  logic             err_set_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             count_en_s;
  logic             lw_stall_s;
  logic             freeze_s;
  hz_ctrl_t         ctrl_s;

  forward_unit u_fwd_a (
    .rs_e        (hz.rs1E_i),
    .rd_m        (hz.rdM_i),
    .rd_w        (hz.rdW_i),
    .reg_write_m (hz.regWriteM_i),
    .reg_write_w (hz.regWriteW_i),
    .fwd_sel     (hz.forwardAE_o)
  );

  forward_unit u_fwd_b (
    .rs_e        (hz.rs2E_i),
    .rd_m        (hz.rdM_i),
    .rd_w        (hz.rdW_i),
    .reg_write_m (hz.regWriteM_i),
    .reg_write_w (hz.regWriteW_i),
    .fwd_sel     (hz.forwardBE_o)
  );

  assign lw_stall_s = (hz.resultSrcE_i == RESULT_SRC_LOAD) && (hz.rdE_i != 5'd0) &&
                      ((hz.rdE_i == hz.rs1D_i) || (hz.rdE_i == hz.rs2D_i));
  assign freeze_s   = hz.memReqM_i && !hz.memAckM_i;

  // Stall/flush word: a pure function of state and this cycle's inputs.
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      INIT: begin
        ctrl_s.stall_f = 1'b1;
        ctrl_s.flush_d = 1'b1;
        ctrl_s.flush_e = 1'b1;
      end
      RUN, MEM_WAIT: begin
        if (freeze_s) begin
          ctrl_s.stall_f = 1'b1;
          ctrl_s.stall_d = 1'b1;
          ctrl_s.stall_e = 1'b1;
          ctrl_s.stall_m = 1'b1;
          ctrl_s.stall_w = 1'b1;
        end else begin
          ctrl_s.stall_f = lw_stall_s;
          ctrl_s.stall_d = lw_stall_s;
          ctrl_s.flush_d = hz.pcSrcE_i;
          ctrl_s.flush_e = lw_stall_s | hz.pcSrcE_i;
        end
      end
      ERROR: begin
        ctrl_s.stall_f = 1'b1;
        ctrl_s.stall_d = 1'b1;
        ctrl_s.stall_e = 1'b1;
        ctrl_s.stall_m = 1'b1;
        ctrl_s.stall_w = 1'b1;
      end
      default: begin
        ctrl_s.stall_f = 1'b1;
        ctrl_s.flush_d = 1'b1;
        ctrl_s.flush_e = 1'b1;
      end
    endcase
  end

  // Next-state and cycle counter; an ack on the last allowed wait cycle still wins.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_set_s   = 1'b0;
    case (state_r)
      INIT: begin
        if (cnt_r == INIT_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      RUN: begin
        if (freeze_s) begin
          state_nxt_s = MEM_WAIT;
          cnt_nxt_s   = CW'(1);
        end else begin
          cnt_nxt_s = '0;
        end
      end
      MEM_WAIT: begin
        if (!freeze_s) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = ERROR;
          cnt_nxt_s   = '0;
          err_set_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      ERROR: begin
        state_nxt_s = ERROR;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = INIT;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign count_en_s = ctrl_s.stall_f && ((state_r == RUN) || (state_r == MEM_WAIT));

  // State, sticky error and saturating stall-cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= INIT;
      cnt_r       <= '0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mem_err_r <= mem_err_r | err_set_s;
      if (count_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign hz.stallF_o   = ctrl_s.stall_f;
  assign hz.stallD_o   = ctrl_s.stall_d;
  assign hz.stallE_o   = ctrl_s.stall_e;
  assign hz.stallM_o   = ctrl_s.stall_m;
  assign hz.stallW_o   = ctrl_s.stall_w;
  assign hz.flushD_o   = ctrl_s.flush_d;
  assign hz.flushE_o   = ctrl_s.flush_e;
  assign hz.memErr_o   = mem_err_r;
  assign hz.stallCnt_o = stall_cnt_r;

  hazard_ctrl_chk #(.CNT_W(CNT_W)) u_chk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_error  (state_r == ERROR),
    .stall_e   (ctrl_s.stall_e),
    .flush_d   (ctrl_s.flush_d),
    .flush_e   (ctrl_s.flush_e),
    .mem_err   (mem_err_r),
    .stall_cnt (stall_cnt_r)
  );

endmodule
